// File: rtl/des_pkg.sv
// Shared constants for the DES S-box substitution stage: S1..S8 tables,
// the 32-bit P permutation, the stage FSM encoding and lookup helpers.
package des_pkg;

    localparam int SBOX_NUM = 8;

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } sbox_state_e;

    // Each entry is one box: 64 nibbles, row-major (row*16+col), entry 0 in the top nibble.
    localparam logic [255:0] SBOX [SBOX_NUM] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // Output bit i (0 = MSB) takes input bit P_TABLE[i] (0 = MSB).
    localparam logic [4:0] P_TABLE [32] = '{
        5'd15, 5'd6,  5'd19, 5'd20, 5'd28, 5'd11, 5'd27, 5'd16,
        5'd0,  5'd14, 5'd22, 5'd25, 5'd4,  5'd17, 5'd30, 5'd9,
        5'd1,  5'd7,  5'd23, 5'd13, 5'd31, 5'd26, 5'd2,  5'd8,
        5'd18, 5'd12, 5'd29, 5'd5,  5'd21, 5'd10, 5'd3,  5'd24
    };

    function automatic logic [3:0] sbox_lookup(input logic [2:0] sel, input logic [5:0] addr);
        logic [7:0] base;
        base = 8'd252 - {addr, 2'b00};
        return SBOX[sel][base +: 4];
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] din);
        logic [31:0] dout;
        dout = '0;
        for (int i = 0; i < 32; i++) begin
            dout[5'd31 - 5'(i)] = din[5'd31 - P_TABLE[5'(i)]];
        end
        return dout;
    endfunction

endpackage

// File: rtl/des_sbox_lut.sv
// One combinational DES S-box: selects box sbox_sel (0 = S1) and maps a
// six-bit group to its four-bit substitute using FIPS row/column addressing.
module des_sbox_lut
    import des_pkg::*;
(
    input  logic [2:0] sbox_sel,
    input  logic [5:0] grp_in,
    output logic [3:0] nib_out
);

    logic [1:0] row;
    logic [3:0] col;

    // Outer bits pick the row, inner four bits the column.
    assign row     = {grp_in[5], grp_in[0]};
    assign col     = grp_in[4:1];
    assign nib_out = sbox_lookup(sbox_sel, {row, col});

endmodule

// File: rtl/des_sbox_sub.sv
// DES round S-box substitution stage: GROUPS_PER_CYCLE groups per cycle,
// valid/ready on both sides. Define DES_SBOX_PBOX_EN to apply P before output.
module des_sbox_sub
    import des_pkg::*;
#(
    parameter int GROUPS_PER_CYCLE = 1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [47:0] xor_data_in,
    input  logic        xor_data_in_valid,
    output logic        xor_data_in_ready,
    output logic [31:0] sbox_data_out,
    output logic        sbox_data_out_valid,
    input  logic        sbox_data_out_ready
);

    localparam int G     = GROUPS_PER_CYCLE;
    localparam int NIB_W = 4 * G;
    localparam int GRP_W = 6 * G;

    if (!(G == 1 || G == 2 || G == 4 || G == 8)) begin : g_bad_groups
        $error("des_sbox_sub: GROUPS_PER_CYCLE=%0d is not one of 1,2,4,8", G);
    end

    sbox_state_e      state;
    sbox_state_e      state_next;
    logic [2:0]       idx;
    logic [47:0]      in_reg;
    logic [31:0]      acc_reg;
    logic [31:0]      out_reg;
    logic [NIB_W-1:0] sub_nibs;
    logic [31:0]      acc_next;
    logic [31:0]      out_word;
    logic             last_step;
    logic             in_ready_c;
    logic             out_valid_c;

    // in_reg shifts left each SUB cycle, so group idx+j always sits at slot j.
    for (genvar j = 0; j < G; j++) begin : g_lut
        des_sbox_lut u_lut (
            .sbox_sel (idx + 3'(j)),
            .grp_in   (in_reg[47-6*j -: 6]),
            .nib_out  (sub_nibs[NIB_W-1-4*j -: 4])
        );
    end

    assign last_step = ({1'b0, idx} + 4'(G)) == 4'd8;
    assign acc_next  = (acc_reg << NIB_W) | 32'(sub_nibs);

`ifdef DES_SBOX_PBOX_EN
    assign out_word = p_perm(acc_next);
`else
    assign out_word = acc_next;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every variable here gets a default first, so no path infers a latch.
        state_next  = state;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (xor_data_in_valid) state_next = SUB;
            end
            SUB: begin
                if (last_step) state_next = DONE;
            end
            DONE: begin
                out_valid_c = 1'b1;
                if (sbox_data_out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        // NOTE: datapath regs are reset too, so an aborted word leaves no residue
        // and the output reads zero straight after reset.
        if (rst_in) begin
            idx     <= '0;
            in_reg  <= '0;
            acc_reg <= '0;
            out_reg <= '0;
        end else begin
            // NOTE: non-blocking updates make every register see pre-edge values.
            unique case (state)
                IDLE: begin
                    if (xor_data_in_valid) begin
                        in_reg  <= xor_data_in;
                        acc_reg <= '0;
                        idx     <= '0;
                    end
                end
                SUB: begin
                    in_reg  <= in_reg << GRP_W;
                    acc_reg <= acc_next;
                    idx     <= idx + 3'(G);
                    if (last_step) out_reg <= out_word;
                end
                default: ;
            endcase
        end
    end

    assign xor_data_in_ready   = in_ready_c;
    assign sbox_data_out_valid = out_valid_c;
    assign sbox_data_out       = out_reg;

endmodule

// File: tb/tb_des_sbox_sub.sv
// Directed self-checking bench for des_sbox_sub: hand vectors, latency for
// G=1/2/4/8, backpressure, mid-word reset, streaming and per-box sweep.
module tb_des_sbox_sub;

    localparam int N_B2B = 16;

    // FIPS 46-3 S-box rows, index box*4+row, column 0 in the top nibble.
    localparam logic [63:0] TB_ROW [32] = '{
        64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
        64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
        64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
        64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
        64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
        64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
        64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
        64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B
    };

`ifdef DES_SBOX_PBOX_EN
    localparam int TB_P [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                 2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
    localparam logic [31:0] EXP_VEC1 = 32'h234AA9BB;
`else
    localparam logic [31:0] EXP_VEC1 = 32'h5C82B597;
`endif

    logic        clk_in;
    logic        rst_in;
    logic [47:0] xor_data_in;
    logic        xor_data_in_valid;
    logic        xor_data_in_ready;
    logic [31:0] sbox_data_out;
    logic        sbox_data_out_valid;
    logic        sbox_data_out_ready;

    logic [47:0] m_data;
    logic        m_valid;
    logic        m_out_ready;
    logic        m_in_ready  [3];
    logic [31:0] m_out       [3];
    logic        m_out_valid [3];

    int n_checks = 0;
    int n_errors = 0;

    des_sbox_sub u_dut (
        .clk_in              (clk_in),
        .rst_in              (rst_in),
        .xor_data_in         (xor_data_in),
        .xor_data_in_valid   (xor_data_in_valid),
        .xor_data_in_ready   (xor_data_in_ready),
        .sbox_data_out       (sbox_data_out),
        .sbox_data_out_valid (sbox_data_out_valid),
        .sbox_data_out_ready (sbox_data_out_ready)
    );

    for (genvar k = 0; k < 3; k++) begin : g_wide
        des_sbox_sub #(.GROUPS_PER_CYCLE(2 << k)) u_dut_g (
            .clk_in              (clk_in),
            .rst_in              (rst_in),
            .xor_data_in         (m_data),
            .xor_data_in_valid   (m_valid),
            .xor_data_in_ready   (m_in_ready[k]),
            .sbox_data_out       (m_out[k]),
            .sbox_data_out_valid (m_out_valid[k]),
            .sbox_data_out_ready (m_out_ready)
        );
    end

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] ref_sub(input logic [47:0] d);
        logic [31:0] r;
        logic [5:0]  g;
        logic [63:0] row_bits;
        int          col;
        r = '0;
        for (int b = 0; b < 8; b++) begin
            g        = d[47-6*b -: 6];
            row_bits = TB_ROW[b*4 + int'({g[5], g[0]})];
            col      = int'(g[4:1]);
            r[31-4*b -: 4] = row_bits[63-4*col -: 4];
        end
`ifdef DES_SBOX_PBOX_EN
        begin
            logic [31:0] p;
            for (int i = 0; i < 32; i++) p[31-i] = r[32-TB_P[i]];
            r = p;
        end
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Offers one word to the G=1 DUT and waits for its result; optionally completes the handshake.
    task automatic run_word(input logic [47:0] d, input logic [31:0] exp, input string tag,
                            input bit chk_lat, input bit release_out);
        int cnt;
        xor_data_in       = d;
        xor_data_in_valid = 1'b1;
        tick();
        xor_data_in_valid = 1'b0;
        xor_data_in       = ~d;
        cnt = 0;
        while (!sbox_data_out_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        if (chk_lat || cnt >= 40) check({tag, " latency"}, 64'(cnt), 64'd8);
        check({tag, " data"}, 64'(sbox_data_out), 64'(exp));
        if (release_out) tick();
    endtask

    initial begin
        logic [31:0] exp_q[$];
        logic [31:0] got_g [3];
        int          lat_g [3];
        logic [31:0] exp_zero;
        logic [31:0] exp_front;
        logic [5:0]  v6;
        bit          acc;
        int          n_sent;
        int          n_recv;
        int          cyc;

        exp_zero = ref_sub(48'h0);
        rst_in              = 1'b1;
        xor_data_in         = '0;
        xor_data_in_valid   = 1'b0;
        sbox_data_out_ready = 1'b1;
        m_data              = '0;
        m_valid             = 1'b0;
        m_out_ready         = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;

        check("reset out_valid", 64'(sbox_data_out_valid), 64'd0);
        check("reset out",       64'(sbox_data_out),       64'd0);
        check("reset in_ready",  64'(xor_data_in_ready),   64'd1);

        run_word(48'h6117BA866527, EXP_VEC1, "vec1", 1'b1, 1'b1);
        check("vec1 release out_valid", 64'(sbox_data_out_valid), 64'd0);
        check("vec1 release in_ready",  64'(xor_data_in_ready),   64'd1);

`ifndef DES_SBOX_PBOX_EN
        check("zero model", 64'(exp_zero), 64'h00000000EFA72C4D);
`endif
        run_word(48'h000000000000, exp_zero, "zero g1", 1'b1, 1'b1);

        // Wider datapaths: same results, latency 8/G.
        for (int pass = 0; pass < 2; pass++) begin
            m_data  = (pass == 0) ? 48'h000000000000 : 48'h6117BA866527;
            m_valid = 1'b1;
            tick();
            m_valid = 1'b0;
            m_data  = 48'hFFFFFFFFFFFF;
            for (int k = 0; k < 3; k++) lat_g[k] = 0;
            for (int c = 1; c <= 12; c++) begin
                tick();
                for (int k = 0; k < 3; k++) begin
                    if (m_out_valid[k] && lat_g[k] == 0) begin
                        lat_g[k] = c;
                        got_g[k] = m_out[k];
                    end
                end
            end
            for (int k = 0; k < 3; k++) begin
                check($sformatf("g%0d pass%0d latency", 2 << k, pass), 64'(lat_g[k]), 64'(8 / (2 << k)));
                check($sformatf("g%0d pass%0d data", 2 << k, pass), 64'(got_g[k]),
                      64'((pass == 0) ? exp_zero : EXP_VEC1));
            end
        end

        // Backpressure in DONE with a stray input pulse that must be ignored.
        sbox_data_out_ready = 1'b0;
        run_word(48'h6117BA866527, EXP_VEC1, "bp", 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            xor_data_in       = 48'h0;
            xor_data_in_valid = (i == 1);
            tick();
            check($sformatf("bp hold%0d valid", i), 64'(sbox_data_out_valid), 64'd1);
            check($sformatf("bp hold%0d data", i),  64'(sbox_data_out),       64'(EXP_VEC1));
            check($sformatf("bp hold%0d in_ready", i), 64'(xor_data_in_ready), 64'd0);
        end
        xor_data_in_valid   = 1'b0;
        sbox_data_out_ready = 1'b1;
        tick();
        check("bp release out_valid", 64'(sbox_data_out_valid), 64'd0);
        check("bp release in_ready",  64'(xor_data_in_ready),   64'd1);

        // Reset in the middle of SUB (idx=3).
        xor_data_in       = 48'h6117BA866527;
        xor_data_in_valid = 1'b1;
        tick();
        xor_data_in_valid = 1'b0;
        repeat (3) tick();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        check("midreset out_valid", 64'(sbox_data_out_valid), 64'd0);
        check("midreset out",       64'(sbox_data_out),       64'd0);
        check("midreset in_ready",  64'(xor_data_in_ready),   64'd1);
        run_word(48'h6117BA866527, EXP_VEC1, "post reset", 1'b1, 1'b1);

        // Streaming: in_valid held high, out_ready random, results in order.
        n_sent = 0;
        n_recv = 0;
        cyc    = 0;
        xor_data_in       = {16'($urandom()), $urandom()};
        xor_data_in_valid = 1'b1;
        while (n_recv < N_B2B && cyc < 3000) begin
            sbox_data_out_ready = 1'($urandom_range(0, 1));
            acc = xor_data_in_valid && xor_data_in_ready;
            if (acc) begin
                exp_q.push_back(ref_sub(xor_data_in));
                n_sent++;
            end
            if (sbox_data_out_valid && sbox_data_out_ready) begin
                if (exp_q.size() == 0) begin
                    check("b2b unexpected word", 64'(exp_q.size()), 64'd1);
                end else begin
                    exp_front = exp_q.pop_front();
                    check($sformatf("b2b word%0d", n_recv), 64'(sbox_data_out), 64'(exp_front));
                end
                n_recv++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (n_sent < N_B2B) xor_data_in = {16'($urandom()), $urandom()};
                else xor_data_in_valid = 1'b0;
            end
        end
        xor_data_in_valid   = 1'b0;
        sbox_data_out_ready = 1'b1;
        check("b2b words received", 64'(n_recv), 64'(N_B2B));
        repeat (2) tick();

        // Every box sees the same six-bit value: each nibble is that box's table entry.
        for (int v = 0; v < 64; v++) begin
            v6 = 6'(v);
            run_word({8{v6}}, ref_sub({8{v6}}), $sformatf("sweep%0d", v), 1'b0, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
